// File: rtl/tdm_pkg.sv
// Shared types and constants for the four-channel TDM demultiplexer.
package tdm_pkg;

    localparam int NCH = 4;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_e;

    typedef logic [1:0] slot_t;

endpackage

// File: rtl/tdm_bit_slot_cnt.sv
// Bit-within-slot and slot-within-frame position counters for the TDM receiver.
module tdm_bit_slot_cnt
    import tdm_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  adv_i,
    input  logic  restart_i,
    output slot_t slot_o,
    output logic  last_bit_o,
    output logic  boundary_o
);

    localparam int BW = (DW > 2) ? $clog2(DW) : 1;

    logic [BW-1:0] bit_q, bit_d;
    slot_t         slot_q, slot_d;

    assign last_bit_o = (bit_q == BW'(DW - 1));
    assign boundary_o = (bit_q == '0) && (slot_q == '0);
    assign slot_o     = slot_q;

    // A restart consumes the sync bit itself, so the next bit is bit 1 of slot 0.
    always_comb begin
        bit_d  = bit_q;
        slot_d = slot_q;
        if (restart_i) begin
            bit_d  = BW'(1);
            slot_d = '0;
        end else if (adv_i) begin
            if (last_bit_o) begin
                bit_d  = '0;
                slot_d = slot_q + 2'd1;
            end else begin
                bit_d  = bit_q + BW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_q  <= '0;
            slot_q <= '0;
        end else begin
            bit_q  <= bit_d;
            slot_q <= slot_d;
        end
    end

endmodule

// File: rtl/tdm_demux4.sv
// Four-channel TDM receiver: frame-sync hunting, serial-to-parallel conversion
// and per-channel word registers with valid pulses and framing-error reporting.
module tdm_demux4
    import tdm_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sd_i,
    input  logic              sv_i,
    input  logic              fs_i,
    output logic [NCH*DW-1:0] ch_data_o,
    output logic [NCH-1:0]    ch_vld_o,
    output logic              frame_done_o,
    output logic              sync_err_o,
    output logic              locked_o
);

    state_e            state_q, state_d;
    logic [DW-2:0]     sh_q;
    logic [DW-1:0]     word;
    logic [NCH*DW-1:0] ch_data_q;
    logic [NCH-1:0]    ch_vld_q;
    logic              frame_done_q;
    logic              sync_err_q;

    logic  adv, restart, shift_en, wr, err;
    slot_t slot;
    logic  last_bit, boundary;

    tdm_bit_slot_cnt #(.DW(DW)) u_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .adv_i      (adv),
        .restart_i  (restart),
        .slot_o     (slot),
        .last_bit_o (last_bit),
        .boundary_o (boundary)
    );

    // Only DW-1 history bits are stored; the live bit completes the word.
    assign word = {sh_q, sd_i};

    always_comb begin
        state_d  = state_q;
        adv      = 1'b0;
        restart  = 1'b0;
        shift_en = 1'b0;
        wr       = 1'b0;
        err      = 1'b0;
        if (sv_i) begin
            case (state_q)
                HUNT: begin
                    if (fs_i) begin
                        restart  = 1'b1;
                        shift_en = 1'b1;
                        state_d  = LOCKED;
                    end
                end
                LOCKED: begin
                    if (boundary) begin
                        if (fs_i) begin
                            adv      = 1'b1;
                            shift_en = 1'b1;
                        end else begin
                            err     = 1'b1;
                            state_d = HUNT;
                        end
                    end else if (fs_i) begin
                        // Early sync: abandon the partial word and realign on this bit.
                        err      = 1'b1;
                        restart  = 1'b1;
                        shift_en = 1'b1;
                    end else begin
                        adv      = 1'b1;
                        shift_en = 1'b1;
                        wr       = last_bit;
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= HUNT;
            sh_q         <= '0;
            ch_data_q    <= '0;
            ch_vld_q     <= '0;
            frame_done_q <= 1'b0;
            sync_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            if (shift_en) begin
                sh_q <= word[DW-2:0];
            end
            ch_vld_q     <= wr ? (NCH'(1) << slot) : '0;
            frame_done_q <= wr && (slot == slot_t'(NCH - 1));
            sync_err_q   <= err;
            for (int k = 0; k < NCH; k++) begin
                if (wr && (slot == slot_t'(k))) begin
                    ch_data_q[k*DW +: DW] <= word;
                end
            end
        end
    end

    assign ch_data_o    = ch_data_q;
    assign ch_vld_o     = ch_vld_q;
    assign frame_done_o = frame_done_q;
    assign sync_err_o   = sync_err_q;
    assign locked_o     = (state_q == LOCKED);

endmodule

// File: tb/tb_tdm_demux4.sv
// Scoreboard bench for tdm_demux4: directed frames push expected word/error
// events, a negedge monitor pops and compares them as the DUT pulses.
module tb_tdm_demux4;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          sd_i = 1'b0;
    logic          sv_i = 1'b0;
    logic          fs_i = 1'b0;
    logic [4*DW-1:0] ch_data_o;
    logic [3:0]    ch_vld_o;
    logic          frame_done_o;
    logic          sync_err_o;
    logic          locked_o;

    tdm_demux4 #(.DW(DW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sd_i         (sd_i),
        .sv_i         (sv_i),
        .fs_i         (fs_i),
        .ch_data_o    (ch_data_o),
        .ch_vld_o     (ch_vld_o),
        .frame_done_o (frame_done_o),
        .sync_err_o   (sync_err_o),
        .locked_o     (locked_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [3:0]  vld;
        logic        fd;
        logic [31:0] data;
        int          at;
    } exp_t;

    exp_t        vq[$];
    int          eq[$];
    exp_t        e;
    int          ea;
    logic [31:0] shadow = '0;
    int          errors = 0;
    int          checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (ch_vld_o != 4'b0 || frame_done_o) begin
            if (vq.size() == 0) begin
                chk("unexpected_vld_or_frame_done", {59'b0, ch_vld_o, frame_done_o}, 64'b0);
            end else begin
                e = vq.pop_front();
                chk("ch_vld", {60'b0, ch_vld_o}, {60'b0, e.vld});
                chk("frame_done", {63'b0, frame_done_o}, {63'b0, e.fd});
                chk("ch_data", {32'b0, ch_data_o}, {32'b0, e.data});
                chk("vld_cycle", 64'(cyc), 64'(e.at));
            end
        end
        if (sync_err_o) begin
            if (eq.size() == 0) begin
                chk("unexpected_sync_err", 64'd1, 64'd0);
            end else begin
                ea = eq.pop_front();
                chk("sync_err_cycle", 64'(cyc), 64'(ea));
            end
        end
    end

    task automatic tick(input logic sv, input logic sd, input logic fs);
        sv_i = sv;
        sd_i = sd;
        fs_i = fs;
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [7:0] w, input int slot, input bit fs0,
                             input bit gap, input bit exp_on, input bit err0);
        logic [3:0] v;
        for (int i = 0; i < 8; i++) begin
            if (i == 0 && err0) eq.push_back(cyc + 1);
            if (i == 7 && exp_on) begin
                shadow[slot*8 +: 8] = w;
                v = 4'b0001 << slot;
                vq.push_back('{vld: v, fd: (slot == 3), data: shadow, at: cyc + 1});
            end
            tick(1'b1, w[7-i], fs0 && (i == 0));
            if (gap) tick(1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic send_frame(input logic [7:0] w0, input logic [7:0] w1,
                              input logic [7:0] w2, input logic [7:0] w3,
                              input bit gap, input bit err0);
        send_word(w0, 0, 1'b1, gap, 1'b1, err0);
        send_word(w1, 1, 1'b0, gap, 1'b1, 1'b0);
        send_word(w2, 2, 1'b0, gap, 1'b1, 1'b0);
        send_word(w3, 3, 1'b0, gap, 1'b1, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ch_data", {32'b0, ch_data_o}, 64'd0);
        chk("reset_ch_vld", {60'b0, ch_vld_o}, 64'd0);
        chk("reset_frame_done", {63'b0, frame_done_o}, 64'd0);
        chk("reset_sync_err", {63'b0, sync_err_o}, 64'd0);
        chk("reset_locked", {63'b0, locked_o}, 64'd0);
        rst_n = 1'b1;
        tick(1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 20; i++) tick(1'b1, (i % 3) == 0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        chk("prelock_ch_data", {32'b0, ch_data_o}, 64'd0);
        chk("prelock_locked", {63'b0, locked_o}, 64'd0);

        send_frame(8'hA5, 8'h3C, 8'hFF, 8'h00, 1'b0, 1'b0);
        chk("clean_ch_data", {32'b0, ch_data_o}, 64'h00FF3CA5);
        chk("clean_locked", {63'b0, locked_o}, 64'd1);

        send_frame(8'h12, 8'h34, 8'h56, 8'h78, 1'b0, 1'b0);
        chk("second_ch_data", {32'b0, ch_data_o}, 64'h78563412);

        send_frame(8'hA5, 8'h3C, 8'hFF, 8'h00, 1'b1, 1'b0);
        chk("gapped_ch_data", {32'b0, ch_data_o}, 64'h00FF3CA5);
        chk("gapped_locked", {63'b0, locked_o}, 64'd1);

        send_word(8'hA5, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("missing_sync_locked", {63'b0, locked_o}, 64'd0);
        send_word(8'h3C, 1, 1'b0, 1'b0, 1'b0, 1'b0);
        send_word(8'hFF, 2, 1'b0, 1'b0, 1'b0, 1'b0);
        send_word(8'h00, 3, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("hunt_ch_data_held", {32'b0, ch_data_o}, 64'h00FF3CA5);
        send_frame(8'h11, 8'h22, 8'h33, 8'h44, 1'b0, 1'b0);
        chk("recover_ch_data", {32'b0, ch_data_o}, 64'h44332211);
        chk("recover_locked", {63'b0, locked_o}, 64'd1);

        send_word(8'hC3, 0, 1'b1, 1'b0, 1'b1, 1'b0);
        send_word(8'h5A, 1, 1'b0, 1'b0, 1'b1, 1'b0);
        tick(1'b1, 1'b1, 1'b0);
        tick(1'b1, 1'b1, 1'b0);
        tick(1'b1, 1'b1, 1'b0);
        chk("early_partial_held", {32'b0, ch_data_o}, 64'h44335AC3);
        send_frame(8'h81, 8'h42, 8'h24, 8'h18, 1'b0, 1'b1);
        chk("early_ch_data", {32'b0, ch_data_o}, 64'h18244281);
        chk("early_locked", {63'b0, locked_o}, 64'd1);

        send_word(8'h9A, 0, 1'b1, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) tick(1'b1, 1'b1, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("midreset_ch_data", {32'b0, ch_data_o}, 64'd0);
        chk("midreset_ch_vld", {60'b0, ch_vld_o}, 64'd0);
        chk("midreset_locked", {63'b0, locked_o}, 64'd0);
        chk("midreset_sync_err", {63'b0, sync_err_o}, 64'd0);
        shadow = '0;
        tick(1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        tick(1'b0, 1'b0, 1'b0);
        send_frame(8'hDE, 8'hAD, 8'hBE, 8'hEF, 1'b0, 1'b0);
        chk("postreset_ch_data", {32'b0, ch_data_o}, 64'hEFBEADDE);
        chk("postreset_locked", {63'b0, locked_o}, 64'd1);

        repeat (3) tick(1'b0, 1'b0, 1'b0);
        chk("vld_queue_drained", 64'(vq.size()), 64'd0);
        chk("err_queue_drained", 64'(eq.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tdm_demux4.md
# tdm_demux4

Four-channel time-division demultiplexer: the receive end of the serial TDM link whose transmitter selects one of four channels per slot. It takes a serial bitstream with a frame-sync marker and recovers four DW-bit parallel words, one per channel. It reports each word with a per-channel valid pulse and flags framing errors. It sits between the serial link pins and the per-channel consumers.

## Interface
- DW, default 8: bits per slot word; must be at least 2.
- clk  in  1  rising-edge clock for all state.
- rst_n  in  1  asynchronous, active-low reset.
- sd_i  in  1  serial data bit, sent MSB first.
- sv_i  in  1  bit-valid strobe; sd_i and fs_i are sampled only when it is 1. Gaps of any length are allowed.
- fs_i  in  1  frame sync; 1 only on the first bit of slot 0.
- ch_data_o  out  4*DW  recovered words; channel k occupies bits [k*DW +: DW].
- ch_vld_o  out  4  one-cycle pulse; bit k means channel k's word just updated.
- frame_done_o  out  1  one-cycle pulse, coincident with ch_vld_o[3].
- sync_err_o  out  1  one-cycle pulse on any framing violation.
- locked_o  out  1  1 while in the LOCKED state.

## Operation
- Frame format: 4 slots × DW bits. Slot 0 comes first. Each slot carries one channel word, MSB first.
- FSM has two states, HUNT and LOCKED. Reset enters HUNT.
- HUNT rules:
  - Valid bits with fs_i=0 are discarded.
  - A valid bit with fs_i=1 is taken as slot 0, bit 0. It is shifted in, bit_cnt becomes 1, slot_cnt becomes 0, and the FSM moves to LOCKED.
- LOCKED rules:
  - Each valid bit shifts into a DW-bit shift register and advances bit_cnt.
  - At bit_cnt = DW-1, the completed word, including the current bit, is written to ch_data_o[slot_cnt]. ch_vld_o[slot_cnt] pulses, bit_cnt wraps to 0 and slot_cnt increments.
  - slot_cnt wraps from 3 to 0. frame_done_o pulses together with ch_vld_o[3].
- Expected sync at a frame boundary (slot_cnt=0, bit_cnt=0):
  - A valid bit with fs_i=1 is correct and proceeds normally.
  - A valid bit with fs_i=0 causes a sync_err_o pulse. The bit is dropped and the FSM returns to HUNT.
- Early sync: a valid bit with fs_i=1 at any other position causes a sync_err_o pulse. The partial word is discarded, with no ch_vld_o pulse. The bit is taken as slot 0, bit 0 and the FSM stays LOCKED.
- ch_data_o keeps its last value per channel until that channel is overwritten. Errors do not clear it.
- Reset value of every output is 0, including ch_data_o. Counters and the shift register also reset to 0.

## Timing
- Latency: ch_vld_o and the new ch_data_o value appear on the clock edge after the edge that samples the last bit of a slot. Both are registered.
- sync_err_o and the locked_o change are registered. They appear one cycle after the offending sample.
- With sv_i held at 1 continuously, a frame takes 4*DW cycles and ch_vld_o pulses every DW cycles.
- When sv_i=0, no state changes. Output pulses still drop after exactly one cycle.
- Asserting rst_n=0 mid-frame has immediate effect: outputs go to 0 and the FSM goes to HUNT. Any partial word is lost.

## Structure
- Package tdm_pkg holds:
  - NCH = 4.
  - The state typedef {HUNT, LOCKED}.
  - The slot index typedef (2 bits).
- Sub-module tdm_bit_slot_cnt holds the bit_cnt and slot_cnt counters. Its inputs are an advance enable and a sync-restart. Its outputs are the last-bit-of-slot and frame-boundary flags.
- The top level holds the FSM, the shift register and the output registers.

## Test plan
- Clean frame at DW=8, sv_i held at 1: send 0xA5, 0x3C, 0xFF, 0x00 with fs_i on the first bit.
  - ch_vld_o pulses 1, 2, 4, 8, spaced 8 cycles apart.
  - ch_data_o ends at {0x00, 0xFF, 0x3C, 0xA5}.
  - frame_done_o pulses once and locked_o=1.
- Gapped bits: the same frame with sv_i=0 inserted between every bit. Results must be identical to the clean frame, with no extra pulses.
- Missing sync: after a good frame, the next frame has fs_i=0 on its first bit.
  - sync_err_o pulses, locked_o drops to 0.
  - Bits are ignored until the next fs_i, then recovery follows with correct words.
- Early sync: fs_i=1 on bit 3 of slot 2.
  - sync_err_o pulses and there is no ch_vld_o[2].
  - The next 32 bits decode as a complete frame starting from that bit.
- Reset mid-frame: pull rst_n low during slot 1.
  - All outputs go to 0 immediately and locked_o=0.
  - After release, a fresh clean frame decodes correctly.
- Bits before lock: 20 valid bits with fs_i=0 from reset produce no pulses and leave ch_data_o at 0.
